// File: rtl/snoop_bus_if.sv
// snoop_bus_if: instruction handshake and shared-bus signals between the caches and the snoop controller
interface snoop_bus_if #(parameter int NCACHE = 3);
  logic                instr_valid;
  logic                instr_ready;
  logic [8:0]          instr_in;
  logic [8:0]          instruction;
  logic [1:0]          step;
  logic [8*NCACHE-1:0] bus_from_cache;
  logic [7:0]          bus_to_cache;
  logic                done;
  logic                bus_conflict;
  logic [7:0]          txn_count;
  modport master (
    output instr_valid, instr_in, bus_from_cache,
    input  instr_ready, instruction, step, bus_to_cache, done, bus_conflict, txn_count
  );
  modport slave (
    input  instr_valid, instr_in, bus_from_cache,
    output instr_ready, instruction, step, bus_to_cache, done, bus_conflict, txn_count
  );
endinterface

// File: rtl/snoop_bus_controller.sv
// snoop_bus_controller: sequences the four-phase snoop step, merges cache messages and owns backing memory
module snoop_bus_controller #(
  parameter int NCACHE = 3
) (
  input logic       clock,
  input logic       reset_n,
  snoop_bus_if.slave bus
);
  localparam logic [1:0] INV = 2'b00, RM = 2'b01, WB = 2'b10, RH = 2'b11;
  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;
  state_t          state_q, state_d;
  logic [8:0]      instr_q, instr_d;
  logic [7:0]      btc_q, btc_d, txn_q, txn_d;
  logic            conf_q, conf_d;
  logic [3:0][3:0] mem_q, mem_d;
  logic [7:0]      wb_msg, inv_msg, rm_msg, merged, msg, wb_cnt;
  logic            wb_hit, inv_hit, rm_hit;
  // Merge: scan from the highest index down so the lowest-indexed sender of each type is kept
  always_comb begin
    wb_msg = '0;
    inv_msg = '0;
    rm_msg = '0;
    wb_hit = 1'b0;
    inv_hit = 1'b0;
    rm_hit = 1'b0;
    wb_cnt = '0;
    msg = '0;
    for (int i = NCACHE - 1; i >= 0; i--) begin
      msg = bus.bus_from_cache[8*i +: 8];
      if (msg[7:6] == WB) begin
        wb_msg = msg;
        wb_hit = 1'b1;
        wb_cnt = wb_cnt + 8'd1;
      end
      if (msg[7:6] == INV) begin
        inv_msg = msg;
        inv_hit = 1'b1;
      end
      if (msg[7:6] == RM) begin
        rm_msg = msg;
        rm_hit = 1'b1;
      end
    end
    merged = wb_hit ? wb_msg : inv_hit ? inv_msg : rm_hit ? rm_msg : {RH, instr_q[5:4], 4'b0};
  end
  // Next state: phase sequencing, memory write-backs and the registered bus broadcast
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    btc_d = btc_q;
    txn_d = txn_q;
    mem_d = mem_q;
    conf_d = conf_q | (state_q != IDLE && wb_cnt > 8'd1);
    case (state_q)
      IDLE: if (bus.instr_valid) begin
        instr_d = bus.instr_in;
        state_d = S0;
      end
      S0: begin
        if (merged[7:6] == WB) mem_d[merged[5:4]] = merged[3:0];
        btc_d = {RH, 6'b0};
        state_d = S1;
      end
      S1: begin
        btc_d = merged;
        state_d = S2;
      end
      S2: begin
        if (merged[7:6] == WB) begin
          mem_d[merged[5:4]] = merged[3:0];
          btc_d = merged;
        end else btc_d = {RH, instr_q[5:4], mem_q[instr_q[5:4]]};
        state_d = S3;
      end
      S3: begin
        btc_d = {RH, 6'b0};
        txn_d = txn_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers; reset drops any in-flight instruction immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      btc_q <= 8'hC0;
      txn_q <= '0;
      conf_q <= 1'b0;
      mem_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      btc_q <= btc_d;
      txn_q <= txn_d;
      conf_q <= conf_d;
      mem_q <= mem_d;
    end
  end
  assign bus.step = state_q == S0 ? 2'b00 : state_q == S1 ? 2'b01 : state_q == S2 ? 2'b10 : 2'b11;
  assign bus.instr_ready = state_q == IDLE;
  assign bus.done = state_q == S3;
  assign bus.instruction = instr_q;
  assign bus.bus_to_cache = btc_q;
  assign bus.bus_conflict = conf_q;
  assign bus.txn_count = txn_q;
endmodule

// File: tb/tb_snoop_bus_controller.sv
// tb_snoop_bus_controller: scenario tasks with a scoreboard of expected bus broadcasts
module tb_snoop_bus_controller;
  localparam int NC = 3;
  localparam logic [23:0] QUIET = {3{8'hC0}};
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [3:0] model_mem [4];
  logic [7:0] model_txn;
  logic model_conf;
  logic [7:0] exp_q [$];
  logic [7:0] fill;
  snoop_bus_if #(.NCACHE(NC)) bus ();
  snoop_bus_controller #(.NCACHE(NC)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;

  // Reference merge: apply types lowest priority first so later (higher) ones override;
  // within a type scan downward so the lowest cache index is applied last
  function automatic logic [7:0] ref_merge(input logic [23:0] v, input logic [1:0] tag);
    logic [7:0] r;
    logic [1:0] t;
    r = {2'b11, tag, 4'b0};
    for (int p = 0; p < 3; p++) begin
      t = p == 0 ? 2'b01 : p == 1 ? 2'b00 : 2'b10;
      for (int i = NC - 1; i >= 0; i--) if (v[8*i+6 +: 2] == t) r = v[8*i +: 8];
    end
    return r;
  endfunction

  function automatic int wb_count(input logic [23:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NC; i++) if (v[8*i+6 +: 2] == 2'b10) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_mem[i] = 4'h0;
    model_txn = 8'h0;
    model_conf = 1'b0;
    exp_q.delete();
  endtask

  // One full transaction: m0/m1/m2 are the cache messages during steps 00/01/10
  task automatic run_txn(input string name, input logic [8:0] ins, input logic [23:0] m0, m1, m2, output logic [7:0] f);
    logic [7:0] x;
    logic [1:0] tag;
    tag = ins[5:4];
    @(negedge clock);
    tests++; if (bus.instr_ready !== 1'b1) begin fails++; $display("FAIL %s T0 ready got %b want 1", name, bus.instr_ready); end
    bus.instr_valid = 1'b1;
    bus.instr_in = ins;
    bus.bus_from_cache = QUIET;
    @(negedge clock);
    bus.instr_valid = 1'b0;
    tests++; if ({bus.step, bus.done, bus.instr_ready, bus.bus_to_cache} !== {2'b00, 1'b0, 1'b0, 8'hC0}) begin
      fails++; $display("FAIL %s T1 step/done/ready/bus got %b/%b/%b/%h want 00/0/0/c0", name, bus.step, bus.done, bus.instr_ready, bus.bus_to_cache);
    end
    tests++; if (bus.instruction !== ins) begin fails++; $display("FAIL %s instruction got %b want %b", name, bus.instruction, ins); end
    bus.bus_from_cache = m0;
    x = ref_merge(m0, tag);
    if (x[7:6] == 2'b10) model_mem[x[5:4]] = x[3:0];
    if (wb_count(m0) > 1) model_conf = 1'b1;
    @(negedge clock);
    tests++; if ({bus.step, bus.done, bus.bus_to_cache} !== {2'b01, 1'b0, 8'hC0}) begin
      fails++; $display("FAIL %s T2 step/done/bus got %b/%b/%h want 01/0/c0", name, bus.step, bus.done, bus.bus_to_cache);
    end
    bus.bus_from_cache = m1;
    exp_q.push_back(ref_merge(m1, tag));
    if (wb_count(m1) > 1) model_conf = 1'b1;
    @(negedge clock);
    tests++; if ({bus.step, bus.done} !== {2'b10, 1'b0}) begin fails++; $display("FAIL %s T3 step/done got %b/%b want 10/0", name, bus.step, bus.done); end
    x = exp_q.pop_front();
    tests++; if (bus.bus_to_cache !== x) begin fails++; $display("FAIL %s T3 snoop bus got %h want %h", name, bus.bus_to_cache, x); end
    bus.bus_from_cache = m2;
    x = ref_merge(m2, tag);
    if (x[7:6] == 2'b10) begin
      model_mem[x[5:4]] = x[3:0];
      exp_q.push_back(x);
    end else exp_q.push_back({2'b11, tag, model_mem[tag]});
    if (wb_count(m2) > 1) model_conf = 1'b1;
    @(negedge clock);
    bus.bus_from_cache = QUIET;
    tests++; if ({bus.step, bus.done} !== {2'b11, 1'b1}) begin fails++; $display("FAIL %s T4 step/done got %b/%b want 11/1", name, bus.step, bus.done); end
    f = bus.bus_to_cache;
    x = exp_q.pop_front();
    tests++; if (f !== x) begin fails++; $display("FAIL %s T4 fill got %h want %h", name, f, x); end
    model_txn = model_txn + 8'd1;
    @(negedge clock);
    tests++; if ({bus.instr_ready, bus.done, bus.bus_to_cache, bus.txn_count, bus.bus_conflict} !== {1'b1, 1'b0, 8'hC0, model_txn, model_conf}) begin
      fails++; $display("FAIL %s T5 ready/done/bus/txn/conf got %b/%b/%h/%0d/%b want 1/0/c0/%0d/%b", name,
        bus.instr_ready, bus.done, bus.bus_to_cache, bus.txn_count, bus.bus_conflict, model_txn, model_conf);
    end
    for (int i = 0; i < 4; i++) begin
      tests++; if (dut.mem_q[i] !== model_mem[i]) begin fails++; $display("FAIL %s mem[%0d] got %h want %h", name, i, dut.mem_q[i], model_mem[i]); end
    end
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    tests++; if ({bus.step, bus.bus_to_cache, bus.instr_ready, bus.done, bus.bus_conflict, bus.txn_count, bus.instruction} !== {2'b11, 8'hC0, 1'b1, 1'b0, 1'b0, 8'h0, 9'h0}) begin
      fails++; $display("FAIL reset outputs got step=%b bus=%h rdy=%b done=%b conf=%b txn=%0d ins=%h", bus.step, bus.bus_to_cache, bus.instr_ready, bus.done, bus.bus_conflict, bus.txn_count, bus.instruction);
    end
    for (int i = 0; i < 4; i++) begin
      tests++; if (dut.mem_q[i] !== 4'h0) begin fails++; $display("FAIL reset mem[%0d] got %h want 0", i, dut.mem_q[i]); end
    end
  endtask

  task automatic test_load_miss();
    run_txn("load_miss", 9'b0_00_10_0000, QUIET, {8'hC0, 8'hC0, 8'h60}, QUIET, fill);
    tests++; if (fill !== 8'hE0) begin fails++; $display("FAIL load_miss fill got %h want e0", fill); end
    tests++; if (bus.txn_count !== 8'd1) begin fails++; $display("FAIL load_miss txn got %0d want 1", bus.txn_count); end
  endtask

  task automatic test_snoop_wb();
    run_txn("snoop_wb", 9'b0_00_10_0000, QUIET, {8'hC0, 8'hC0, 8'h60}, {8'hC0, 8'hA5, 8'hC0}, fill);
    tests++; if (fill !== 8'hA5) begin fails++; $display("FAIL snoop_wb fill got %h want a5", fill); end
    tests++; if (dut.mem_q[2] !== 4'h5) begin fails++; $display("FAIL snoop_wb mem[2] got %h want 5", dut.mem_q[2]); end
  endtask

  task automatic test_victim_wb();
    run_txn("victim_wb", 9'b1_01_01_0011, {8'hC0, 8'h97, 8'hC0}, QUIET, QUIET, fill);
    tests++; if (dut.mem_q[1] !== 4'h7) begin fails++; $display("FAIL victim_wb mem[1] got %h want 7", dut.mem_q[1]); end
    run_txn("victim_load", 9'b0_10_01_0000, QUIET, QUIET, QUIET, fill);
    tests++; if (fill !== 8'hD7) begin fails++; $display("FAIL victim_load fill got %h want d7", fill); end
  endtask

  task automatic test_priority();
    run_txn("priority", 9'b1_00_11_0001, QUIET, {8'h70, 8'h30, 8'h31}, QUIET, fill);
    tests++; if (fill !== 8'hF0) begin fails++; $display("FAIL priority fill got %h want f0", fill); end
  endtask

  task automatic test_conflict();
    run_txn("conflict", 9'b0_00_10_0000, QUIET, QUIET, {8'hA9, 8'hC0, 8'hA3}, fill);
    tests++; if ({fill, dut.mem_q[2], bus.bus_conflict} !== {8'hA3, 4'h3, 1'b1}) begin
      fails++; $display("FAIL conflict fill/mem2/conf got %h/%h/%b want a3/3/1", fill, dut.mem_q[2], bus.bus_conflict);
    end
    run_txn("conflict_hold_owner3", 9'b0_11_00_0000, QUIET, QUIET, QUIET, fill);
    tests++; if (bus.bus_conflict !== 1'b1) begin fails++; $display("FAIL conflict_hold got %b want 1", bus.bus_conflict); end
  endtask

  task automatic test_busy_reset();
    logic [8:0] a, b;
    logic saw_done;
    a = 9'b0_00_00_0101;
    b = 9'b1_10_11_1010;
    @(negedge clock);
    bus.instr_valid = 1'b1;
    bus.instr_in = a;
    bus.bus_from_cache = QUIET;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) bus.instr_in = b;
      tests++; if ({bus.instr_ready, bus.instruction} !== {1'b0, a}) begin
        fails++; $display("FAIL busy T%0d ready/instr got %b/%b want 0/%b", k, bus.instr_ready, bus.instruction, a);
      end
    end
    model_txn = model_txn + 8'd1;
    @(negedge clock);
    tests++; if ({bus.instr_ready, bus.txn_count} !== {1'b1, model_txn}) begin
      fails++; $display("FAIL busy T5 ready/txn got %b/%0d want 1/%0d", bus.instr_ready, bus.txn_count, model_txn);
    end
    @(negedge clock);
    tests++; if ({bus.step, bus.instruction} !== {2'b00, b}) begin
      fails++; $display("FAIL back_to_back step/instr got %b/%b want 00/%b", bus.step, bus.instruction, b);
    end
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clock);
    tests++; if (bus.step !== 2'b10) begin fails++; $display("FAIL pre_reset step got %b want 10", bus.step); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    tests++; if ({bus.step, bus.instr_ready, bus.done, bus.bus_to_cache, bus.txn_count, bus.bus_conflict} !== {2'b11, 1'b1, 1'b0, 8'hC0, 8'h0, 1'b0}) begin
      fails++; $display("FAIL async_reset step/rdy/done/bus/txn/conf got %b/%b/%b/%h/%0d/%b want 11/1/0/c0/0/0",
        bus.step, bus.instr_ready, bus.done, bus.bus_to_cache, bus.txn_count, bus.bus_conflict);
    end
    for (int i = 0; i < 4; i++) begin
      tests++; if (dut.mem_q[i] !== 4'h0) begin fails++; $display("FAIL async_reset mem[%0d] got %h want 0", i, dut.mem_q[i]); end
    end
    saw_done = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (bus.done !== 1'b0 || bus.step !== 2'b11) saw_done = 1'b1;
    end
    tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL reset_drop done/step activity got %b want 0", saw_done); end
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_in = '0;
    bus.bus_from_cache = QUIET;
    test_reset();
    test_load_miss();
    test_snoop_wb();
    test_victim_wb();
    test_priority();
    test_conflict();
    test_busy_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
